// File: rtl/lcd_power_on_pkg.sv
// Shared definitions for the 4-bit LCD power-on sequencer: timing defaults
// (cycles at 50 MHz), the power-on nibble constants and the FSM encoding.
package lcd_power_on_pkg;

  // Power-on timing defaults in clock cycles.
  localparam int T_PWR_DEF    = 750000; // 15 ms
  localparam int T_SETUP_DEF  = 2;
  localparam int T_E_HIGH_DEF = 12;     // 240 ns
  localparam int T_GAP0_DEF   = 205000; // 4.1 ms
  localparam int T_GAP1_DEF   = 5000;   // 100 us
  localparam int T_GAP2_DEF   = 2000;   // 40 us
  localparam int T_GAP3_DEF   = 2000;   // 40 us
  localparam int CNT_W_DEF    = 20;

  // Command timings used by lcd_control after the handoff.
  localparam int T_CMD_SHORT  = 2078;
  localparam int T_CMD_LONG   = 82000;

  localparam logic [3:0] NIB_WAKE   = 4'h3;
  localparam logic [3:0] NIB_4BIT   = 4'h2;
  localparam logic [3:0] NIB_IDLE   = 4'h0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PWR = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    GAP      = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Power-on nibble for write index 0..3: three wake-ups, then the switch to 4-bit mode.
  function automatic logic [3:0] pwr_nibble(input logic [1:0] idx);
    logic [3:0] nib;
    case (idx)
      2'd0:    nib = NIB_WAKE;
      2'd1:    nib = NIB_WAKE;
      2'd2:    nib = NIB_WAKE;
      2'd3:    nib = NIB_4BIT;
      default: nib = NIB_IDLE;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/lcd_power_on.sv
// LCD power-on initialization sequencer: writes 0x3, 0x3, 0x3, 0x2 with the
// mandated delays, then raises a sticky init_done for lcd_control.
module lcd_power_on
  import lcd_power_on_pkg::*;
#(
  parameter int T_PWR    = T_PWR_DEF,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_E_HIGH = T_E_HIGH_DEF,
  parameter int T_GAP0   = T_GAP0_DEF,
  parameter int T_GAP1   = T_GAP1_DEF,
  parameter int T_GAP2   = T_GAP2_DEF,
  parameter int T_GAP3   = T_GAP3_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] sf_d,
  output logic       lcd_e,
  output logic       busy,
  output logic       init_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] LD_PWR    = CNT_W'(T_PWR - 1);
  localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_E_HIGH = CNT_W'(T_E_HIGH - 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [1:0]       idx_r;
  logic [1:0]       idx_s;
  logic [3:0]       sf_d_s;
  logic             lcd_e_s;
  logic             busy_s;
  logic             init_done_s;

  // Gap length after write idx, as a counter reload value.
  function automatic logic [CNT_W-1:0] gap_load(input logic [1:0] idx);
    logic [CNT_W-1:0] ld;
    case (idx)
      2'd0:    ld = CNT_W'(T_GAP0 - 1);
      2'd1:    ld = CNT_W'(T_GAP1 - 1);
      2'd2:    ld = CNT_W'(T_GAP2 - 1);
      2'd3:    ld = CNT_W'(T_GAP3 - 1);
      default: ld = CNT_W'(T_GAP3 - 1);
    endcase
    return ld;
  endfunction

  // Next-state, counter and write-index decode; each timed state loads N-1 on entry.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WAIT_PWR;
          cnt_s   = LD_PWR;
          idx_s   = 2'd0;
        end else begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
          idx_s   = 2'd0;
        end
      end
      WAIT_PWR: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = SETUP;
          cnt_s   = LD_SETUP;
          idx_s   = 2'd0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = PULSE;
          cnt_s   = LD_E_HIGH;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = GAP;
          cnt_s   = gap_load(idx_r);
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_ONE;
        end else if (idx_r == 2'd3) begin
          state_s = DONE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = SETUP;
          cnt_s   = LD_SETUP;
          idx_s   = idx_r + 2'd1;
        end
      end
      DONE: begin
        state_s = DONE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = 2'd0;
      end
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state so the pins are plain flops.
  always_comb begin
    sf_d_s      = NIB_IDLE;
    lcd_e_s     = 1'b0;
    busy_s      = 1'b0;
    init_done_s = 1'b0;
    case (state_s)
      IDLE: begin
        busy_s = 1'b0;
      end
      WAIT_PWR: begin
        busy_s = 1'b1;
      end
      SETUP: begin
        sf_d_s = pwr_nibble(idx_s);
        busy_s = 1'b1;
      end
      PULSE: begin
        sf_d_s  = pwr_nibble(idx_s);
        lcd_e_s = 1'b1;
        busy_s  = 1'b1;
      end
      GAP: begin
        sf_d_s = pwr_nibble(idx_s);
        busy_s = 1'b1;
      end
      DONE: begin
        init_done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  // State, counter, index and registered pin outputs; reset clears lcd_e immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      idx_r     <= 2'd0;
      sf_d      <= NIB_IDLE;
      lcd_e     <= 1'b0;
      busy      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      sf_d      <= sf_d_s;
      lcd_e     <= lcd_e_s;
      busy      <= busy_s;
      init_done <= init_done_s;
    end
  end

endmodule
